// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/subtract sequencer. It steps one external 4-bit adder slice
// through the operands one nibble per cycle, LSB first, and chains the carry between steps.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble per cycle through the external adder
// DONE  | result presented, waiting for out_ready
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             last_step;

    assign last_step = (cnt == CW'(NIB - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_sh[3:0];
                add_b   = b_sh[3:0];
                add_cin = carry_q;
                if (last_step) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: B is inverted at load and the +1 enters as the first carry-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            cnt         <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= op_a;
                        b_sh    <= op_sub ? ~op_b : op_b;
                        carry_q <= op_sub;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    carry_q <= add_cout;
                    a_sh    <= {4'h0, a_sh[WIDTH-1:4]};
                    b_sh    <= {4'h0, b_sh[WIDTH-1:4]};
                    res_sh  <= {add_sum, res_sh[WIDTH-1:4]};
                    cnt     <= cnt + CW'(1);
                    if (last_step) begin
                        carry_out_q <= add_cout;
                        // Carry into bit 3 is a^b^sum there; overflow when it differs from cout.
                        overflow_q  <= add_a[3] ^ add_b[3] ^ add_sum[3] ^ add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = res_sh;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl at WIDTH=16, with a behavioural 4-bit ripple adder.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        carry_out, overflow, busy;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        logic [4:0] t;
        t = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};
        add_sum  = t[3:0];
        add_cout = t[4];
    end

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // Presents one operation and waits (bounded) for out_valid; leaves the result pending.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          output int lat, output logic [3:0] cin_seq, output logic [3:0] first_b);
        @(negedge clk);
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0; cin_seq = 4'h0; first_b = 4'h0;
        while (!out_valid && lat < 20) begin
            if (busy) cin_seq = {cin_seq[2:0], add_cin};
            if (lat == 0) first_b = add_b;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0;
        #12;
        vectors++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_flags: {in_ready,out_valid,busy}=%b required 100", {in_ready, out_valid, busy});
        end
        vectors++;
        if ({result, carry_out, overflow, add_a, add_b, add_cin} !== 27'h0) begin
            miscompares++;
            $display("FAIL reset_data: result=%h co=%b ov=%b add_a=%h add_b=%h cin=%b required all zero",
                     result, carry_out, overflow, add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int lat; logic [3:0] cs, fb;
        logic [15:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
        logic [15:0] vb [3] = '{16'h0FFF, 16'h0001, 16'h0001};
        logic [15:0] er [3] = '{16'h2233, 16'h0000, 16'h8000};
        logic [1:0]  ef [3] = '{2'b00, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, lat, cs, fb);
            vectors++;
            if (lat !== 4) begin
                miscompares++;
                $display("FAIL add_latency[%0d]: got %0d cycles required 4", i, lat);
            end
            vectors++;
            if ({result, carry_out, overflow} !== {er[i], ef[i]}) begin
                miscompares++;
                $display("FAIL add_result[%0d]: got %h co=%b ov=%b required %h co=%b ov=%b",
                         i, result, carry_out, overflow, er[i], ef[i][1], ef[i][0]);
            end
            if (i == 1) begin
                vectors++;
                if (cs !== 4'b0111) begin
                    miscompares++;
                    $display("FAIL add_cin_seq: got %b required 0111", cs);
                end
            end
            release_op();
        end
    endtask

    task automatic test_sub();
        int lat; logic [3:0] cs, fb;
        run_op(16'h0005, 16'h0007, 1'b1, lat, cs, fb);
        vectors++;
        if (fb !== 4'h8 || cs[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL sub_first_nibble: add_b=%h cin=%b required 8 and 1", fb, cs[3]);
        end
        vectors++;
        if ({result, carry_out, overflow} !== {16'hFFFE, 2'b00}) begin
            miscompares++;
            $display("FAIL sub_5_7: got %h co=%b ov=%b required fffe co=0 ov=0", result, carry_out, overflow);
        end
        release_op();
        run_op(16'h8000, 16'h0001, 1'b1, lat, cs, fb);
        vectors++;
        if ({result, carry_out, overflow} !== {16'h7FFF, 2'b11}) begin
            miscompares++;
            $display("FAIL sub_8000_1: got %h co=%b ov=%b required 7fff co=1 ov=1", result, carry_out, overflow);
        end
        release_op();
    endtask

    task automatic test_hold();
        int lat; logic [3:0] cs, fb;
        int bad = 0;
        run_op(16'h00AB, 16'h0011, 1'b0, lat, cs, fb);
        op_a = 16'h5555; op_b = 16'h1111; op_sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (result !== 16'h00BC || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL hold_stable: %0d bad cycles, last result=%h in_ready=%b out_valid=%b required 00bc 0 1",
                     bad, result, in_ready, out_valid);
        end
        in_valid = 1'b0;
        release_op();
        vectors++;
        if ({in_ready, out_valid, busy, result} !== {3'b100, 16'h00BC}) begin
            miscompares++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b result=%h required 1 0 0 00bc",
                     in_ready, out_valid, busy, result);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [3:0] cs, fb;
        op_a = 16'h1111; op_b = 16'h2222; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, busy, result, in_ready} !== {2'b00, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_run_reset: out_valid=%b busy=%b result=%h in_ready=%b required 0 0 0000 1",
                     out_valid, busy, result, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0, lat, cs, fb);
        vectors++;
        if (lat !== 4 || result !== 16'h0002) begin
            miscompares++;
            $display("FAIL after_reset_op: result=%h lat=%0d required 0002 lat 4", result, lat);
        end
        release_op();
    endtask

    task automatic test_back_to_back();
        int lat; logic [3:0] cs, fb;
        run_op(16'h0000, 16'h0000, 1'b1, lat, cs, fb);
        vectors++;
        if ({result, carry_out, overflow} !== {16'h0000, 2'b10}) begin
            miscompares++;
            $display("FAIL b2b_sub_zero: got %h co=%b ov=%b required 0000 co=1 ov=0", result, carry_out, overflow);
        end
        release_op();
        run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, cs, fb);
        vectors++;
        if (lat !== 4 || {result, carry_out, overflow} !== {16'hFFFE, 2'b10}) begin
            miscompares++;
            $display("FAIL b2b_add_ffff: got %h co=%b ov=%b lat=%0d required fffe co=1 ov=0 lat 4",
                     result, carry_out, overflow, lat);
        end
        release_op();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
